// File: rtl/inst_msg_sequencer_pkg.sv
// Shared definitions for the instruction-message sequencer: FSM state
// encoding, display character geometry and message index constants.
package inst_msg_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2
    } seq_state_e;

    localparam int CHAR_W    = 5;
    localparam int WIN_CHARS = 8;
    localparam int WIN_W     = CHAR_W * WIN_CHARS;
    localparam int ID_W      = 2;

    localparam logic [CHAR_W-1:0] BLANK_CHAR   = 5'b00000;
    localparam logic [WIN_W-1:0]  BLANK_WINDOW = {WIN_CHARS{BLANK_CHAR}};

    localparam logic [ID_W-1:0] MSG_ID_0 = 2'd0;
    localparam logic [ID_W-1:0] MSG_ID_1 = 2'd1;
    localparam logic [ID_W-1:0] MSG_ID_2 = 2'd2;
    localparam logic [ID_W-1:0] MSG_ID_3 = 2'd3;

endpackage

// File: rtl/inst_msg_sequencer_slot_mux.sv
// Combinational selector that picks one 40-bit generator window out of the
// packed generator bus. An out-of-range index yields a blank window.
module inst_slot_mux
    import inst_msg_sequencer_pkg::*;
#(
    parameter int N_SRC = 4
) (
    input  logic [WIN_W*N_SRC-1:0] inst_bus,
    input  logic [ID_W-1:0]        sel,
    output logic [WIN_W-1:0]       slot
);

    // Walk every slot and forward the one whose index matches sel.
    always_comb begin
        slot = BLANK_WINDOW;
        for (int k = 0; k < N_SRC; k++) begin
            if (int'(sel) == k) begin
                slot = inst_bus[WIN_W*k +: WIN_W];
            end else begin
                slot = slot;
            end
        end
    end

endmodule

// File: rtl/inst_msg_sequencer.sv
// Instruction-message sequencer: accepts a request for one of N_SRC prompt
// generators, releases that generator from reset, and forwards its scrolling
// window for REPEATS passes of PASS_TICKS ticks each. A request for a
// different generator preempts the current one; abort and rst return to IDLE.
module inst_msg_sequencer
    import inst_msg_sequencer_pkg::*;
#(
    parameter int N_SRC      = 4,
    parameter int PASS_TICKS = 25,
    parameter int REPEATS    = 2
) (
    input  logic                   sec_clock,
    input  logic                   rst,
    input  logic                   req_valid,
    input  logic [ID_W-1:0]        msg_id,
    input  logic                   abort,
    input  logic [WIN_W*N_SRC-1:0] inst_bus,
    output logic [N_SRC-1:0]       inst_rst,
    output logic [WIN_W-1:0]       window,
    output logic                   busy,
    output logic                   req_ack,
    output logic                   msg_done
);

    localparam int TICK_W = (PASS_TICKS > 1) ? $clog2(PASS_TICKS) : 1;
    localparam int PASS_W = (REPEATS > 1) ? $clog2(REPEATS) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(PASS_TICKS - 1);
    localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(REPEATS - 1);
    localparam logic [N_SRC-1:0]  ALL_ONES  = {N_SRC{1'b1}};

    seq_state_e         state_q, state_d;
    logic [ID_W-1:0]    active_id_q, active_id_d;
    logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [PASS_W-1:0]  pass_cnt_q, pass_cnt_d;
    logic [N_SRC-1:0]   inst_rst_q, inst_rst_d;
    logic [WIN_W-1:0]   window_q, window_d;
    logic               req_ack_q, req_ack_d;
    logic               msg_done_q, msg_done_d;

    logic [WIN_W-1:0]   slot_s;
    logic [N_SRC-1:0]   play_mask_s;
    logic               id_ok_s;
    logic               last_tick_s;
    logic               final_tick_s;

    inst_slot_mux #(
        .N_SRC (N_SRC)
    ) u_slot_mux (
        .inst_bus (inst_bus),
        .sel      (active_id_q),
        .slot     (slot_s)
    );

    // Decode helper conditions shared by the next-state logic.
    always_comb begin
        id_ok_s      = (int'(msg_id) < N_SRC);
        play_mask_s  = ALL_ONES & ~(N_SRC'(1'b1) << active_id_q);
        last_tick_s  = (tick_cnt_q == TICK_LAST);
        final_tick_s = last_tick_s && (pass_cnt_q == PASS_LAST);
    end

    // Next-state, counter and output computation; abort overrides everything.
    always_comb begin
        state_d     = state_q;
        active_id_d = active_id_q;
        tick_cnt_d  = tick_cnt_q;
        pass_cnt_d  = pass_cnt_q;
        inst_rst_d  = inst_rst_q;
        window_d    = window_q;
        req_ack_d   = 1'b0;
        msg_done_d  = 1'b0;

        if (abort) begin
            state_d    = ST_IDLE;
            tick_cnt_d = '0;
            pass_cnt_d = '0;
            inst_rst_d = ALL_ONES;
            window_d   = BLANK_WINDOW;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    inst_rst_d = ALL_ONES;
                    window_d   = BLANK_WINDOW;
                    tick_cnt_d = '0;
                    pass_cnt_d = '0;
                    if (req_valid && id_ok_s) begin
                        active_id_d = msg_id;
                        req_ack_d   = 1'b1;
                        state_d     = ST_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    // Requests are not looked at while the generator restarts.
                    state_d    = ST_PLAY;
                    inst_rst_d = play_mask_s;
                    window_d   = BLANK_WINDOW;
                    tick_cnt_d = '0;
                    pass_cnt_d = '0;
                end
                ST_PLAY: begin
                    window_d = slot_s;
                    if (final_tick_s) begin
                        // Last tick of last pass: finish, but a request on
                        // this same edge is still taken, whatever its id.
                        msg_done_d = 1'b1;
                        tick_cnt_d = '0;
                        pass_cnt_d = '0;
                        inst_rst_d = ALL_ONES;
                        window_d   = BLANK_WINDOW;
                        if (req_valid && id_ok_s) begin
                            req_ack_d   = 1'b1;
                            active_id_d = msg_id;
                            state_d     = ST_LOAD;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else if (req_valid && id_ok_s && (msg_id != active_id_q)) begin
                        // Preempt with a different generator.
                        req_ack_d   = 1'b1;
                        active_id_d = msg_id;
                        state_d     = ST_LOAD;
                        tick_cnt_d  = '0;
                        pass_cnt_d  = '0;
                        inst_rst_d  = ALL_ONES;
                        window_d    = BLANK_WINDOW;
                    end else if (last_tick_s) begin
                        tick_cnt_d = '0;
                        pass_cnt_d = pass_cnt_q + PASS_W'(1'b1);
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1'b1);
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    tick_cnt_d = '0;
                    pass_cnt_d = '0;
                    inst_rst_d = ALL_ONES;
                    window_d   = BLANK_WINDOW;
                end
            endcase
        end
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge sec_clock) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            active_id_q <= '0;
            tick_cnt_q  <= '0;
            pass_cnt_q  <= '0;
            inst_rst_q  <= ALL_ONES;
            window_q    <= BLANK_WINDOW;
            req_ack_q   <= 1'b0;
            msg_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            active_id_q <= active_id_d;
            tick_cnt_q  <= tick_cnt_d;
            pass_cnt_q  <= pass_cnt_d;
            inst_rst_q  <= inst_rst_d;
            window_q    <= window_d;
            req_ack_q   <= req_ack_d;
            msg_done_q  <= msg_done_d;
        end
    end

    assign inst_rst = inst_rst_q;
    assign window   = window_q;
    assign busy     = (state_q != ST_IDLE);
    assign req_ack  = req_ack_q;
    assign msg_done = msg_done_q;

endmodule

// File: tb/tb_inst_msg_sequencer.sv
// Directed self-checking bench for inst_msg_sequencer (default parameters:
// 4 generators, 25 ticks per pass, 2 passes -> 50 PLAY cycles per message).
// Status is checked as the packed vector {busy, req_ack, msg_done, inst_rst}.
module tb_inst_msg_sequencer;

    logic         sec_clock = 1'b0;
    logic         rst       = 1'b0;
    logic         req_valid = 1'b0;
    logic [1:0]   msg_id    = 2'd0;
    logic         abort     = 1'b0;
    logic [159:0] inst_bus  = '0;
    logic [3:0]   inst_rst;
    logic [39:0]  window;
    logic         busy;
    logic         req_ack;
    logic         msg_done;

    int cmp_cnt = 0;
    int err_cnt = 0;

    localparam logic [39:0] SLOT0 = 40'h0A0B0C0D0E;
    localparam logic [39:0] SLOT1 = 40'h123456789A;
    localparam logic [39:0] SLOT2 = 40'h2222233333;
    localparam logic [39:0] SLOT3 = 40'h4444455555;

    inst_msg_sequencer dut (
        .sec_clock (sec_clock),
        .rst       (rst),
        .req_valid (req_valid),
        .msg_id    (msg_id),
        .abort     (abort),
        .inst_bus  (inst_bus),
        .inst_rst  (inst_rst),
        .window    (window),
        .busy      (busy),
        .req_ack   (req_ack),
        .msg_done  (msg_done)
    );

    always #5 sec_clock = ~sec_clock;

    task automatic step();
        @(posedge sec_clock);
        #1;
    endtask

    task automatic load_slots();
        inst_bus = {SLOT3, SLOT2, SLOT1, SLOT0};
    endtask

    // Request id, pass through LOAD; on return the block is at tick 0 of PLAY.
    task automatic start_msg(input logic [1:0] id);
        req_valid = 1'b1;
        msg_id    = id;
        step();
        req_valid = 1'b0;
        step();
    endtask

    task automatic test_reset();
        load_slots();
        rst = 1'b1; req_valid = 1'b1; msg_id = 2'd2; abort = 1'b1;
        step();
        cmp_cnt++;
        if ({busy, req_ack, msg_done, inst_rst} !== 7'b000_1111) begin
            err_cnt++;
            $display("FAIL reset_status: got %b expected %b", {busy, req_ack, msg_done, inst_rst}, 7'b000_1111);
        end
        cmp_cnt++;
        if (window !== 40'h0) begin
            err_cnt++;
            $display("FAIL reset_window: got %h expected %h", window, 40'h0);
        end
        rst = 1'b0; req_valid = 1'b0; abort = 1'b0;
        step();
        cmp_cnt++;
        if ({busy, req_ack, msg_done, inst_rst} !== 7'b000_1111) begin
            err_cnt++;
            $display("FAIL idle_status: got %b expected %b", {busy, req_ack, msg_done, inst_rst}, 7'b000_1111);
        end
    endtask

    task automatic test_basic_play();
        req_valid = 1'b1; msg_id = 2'd1;
        step();
        cmp_cnt++;
        if ({busy, req_ack, msg_done, inst_rst} !== 7'b110_1111) begin
            err_cnt++;
            $display("FAIL basic_ack: got %b expected %b", {busy, req_ack, msg_done, inst_rst}, 7'b110_1111);
        end
        req_valid = 1'b0;
        step();
        cmp_cnt++;
        if ({busy, req_ack, msg_done, inst_rst} !== 7'b100_1101) begin
            err_cnt++;
            $display("FAIL basic_load_exit: got %b expected %b", {busy, req_ack, msg_done, inst_rst}, 7'b100_1101);
        end
        for (int i = 0; i < 49; i++) begin
            step();
            cmp_cnt++;
            if ({busy, req_ack, msg_done, inst_rst} !== 7'b100_1101 || window !== SLOT1) begin
                err_cnt++;
                $display("FAIL basic_play[%0d]: got %b/%h expected %b/%h", i,
                         {busy, req_ack, msg_done, inst_rst}, window, 7'b100_1101, SLOT1);
            end
        end
        step();
        cmp_cnt++;
        if ({busy, req_ack, msg_done, inst_rst} !== 7'b001_1111 || window !== 40'h0) begin
            err_cnt++;
            $display("FAIL basic_done: got %b/%h expected %b/%h",
                     {busy, req_ack, msg_done, inst_rst}, window, 7'b001_1111, 40'h0);
        end
        step();
        cmp_cnt++;
        if ({busy, req_ack, msg_done, inst_rst} !== 7'b000_1111) begin
            err_cnt++;
            $display("FAIL basic_after_done: got %b expected %b", {busy, req_ack, msg_done, inst_rst}, 7'b000_1111);
        end
    endtask

    task automatic test_window_tracking();
        logic [39:0] v;
        load_slots();
        start_msg(2'd1);
        cmp_cnt++;
        if (window !== 40'h0) begin
            err_cnt++;
            $display("FAIL track_pre_play: got %h expected %h", window, 40'h0);
        end
        for (int i = 0; i < 12; i++) begin
            v = SLOT1 ^ 40'(i * 32'h01010101);
            inst_bus[79:40] = v;
            step();
            cmp_cnt++;
            if (window !== v) begin
                err_cnt++;
                $display("FAIL track_window[%0d]: got %h expected %h", i, window, v);
            end
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        load_slots();
    endtask

    task automatic test_preempt();
        int done_seen;
        done_seen = 0;
        start_msg(2'd0);
        cmp_cnt++;
        if (inst_rst !== 4'b1110) begin
            err_cnt++;
            $display("FAIL preempt_first_rst: got %b expected %b", inst_rst, 4'b1110);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            if (msg_done === 1'b1) done_seen++;
        end
        req_valid = 1'b1; msg_id = 2'd2;
        step();
        req_valid = 1'b0;
        if (msg_done === 1'b1) done_seen++;
        cmp_cnt++;
        if ({busy, req_ack, msg_done, inst_rst} !== 7'b110_1111 || window !== 40'h0) begin
            err_cnt++;
            $display("FAIL preempt_ack: got %b/%h expected %b/%h",
                     {busy, req_ack, msg_done, inst_rst}, window, 7'b110_1111, 40'h0);
        end
        step();
        cmp_cnt++;
        if (inst_rst !== 4'b1011) begin
            err_cnt++;
            $display("FAIL preempt_rst: got %b expected %b", inst_rst, 4'b1011);
        end
        for (int i = 0; i < 49; i++) begin
            step();
            if (msg_done === 1'b1) done_seen++;
            cmp_cnt++;
            if (window !== SLOT2 || busy !== 1'b1) begin
                err_cnt++;
                $display("FAIL preempt_play[%0d]: got %h/%b expected %h/1", i, window, busy, SLOT2);
            end
        end
        step();
        if (msg_done === 1'b1) done_seen++;
        cmp_cnt++;
        if (msg_done !== 1'b1 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL preempt_done: got done=%b busy=%b expected done=1 busy=0", msg_done, busy);
        end
        cmp_cnt++;
        if (done_seen !== 1) begin
            err_cnt++;
            $display("FAIL preempt_done_count: got %0d expected %0d", done_seen, 1);
        end
    endtask

    task automatic test_same_id_and_load();
        req_valid = 1'b1; msg_id = 2'd0;
        step();
        msg_id = 2'd3;
        step();
        cmp_cnt++;
        if ({busy, req_ack, msg_done, inst_rst} !== 7'b100_1110) begin
            err_cnt++;
            $display("FAIL load_ignores_req: got %b expected %b", {busy, req_ack, msg_done, inst_rst}, 7'b100_1110);
        end
        msg_id = 2'd0;
        for (int i = 0; i < 49; i++) begin
            step();
            cmp_cnt++;
            if ({busy, req_ack, msg_done, inst_rst} !== 7'b100_1110) begin
                err_cnt++;
                $display("FAIL same_id_ignored[%0d]: got %b expected %b", i,
                         {busy, req_ack, msg_done, inst_rst}, 7'b100_1110);
            end
        end
        req_valid = 1'b0;
        step();
        cmp_cnt++;
        if ({busy, req_ack, msg_done, inst_rst} !== 7'b001_1111) begin
            err_cnt++;
            $display("FAIL same_id_done: got %b expected %b", {busy, req_ack, msg_done, inst_rst}, 7'b001_1111);
        end
    endtask

    task automatic test_final_collision();
        start_msg(2'd1);
        for (int i = 0; i < 49; i++) step();
        req_valid = 1'b1; msg_id = 2'd3;
        step();
        req_valid = 1'b0;
        cmp_cnt++;
        if ({busy, req_ack, msg_done, inst_rst} !== 7'b111_1111) begin
            err_cnt++;
            $display("FAIL collide_edge: got %b expected %b", {busy, req_ack, msg_done, inst_rst}, 7'b111_1111);
        end
        step();
        cmp_cnt++;
        if ({busy, req_ack, msg_done, inst_rst} !== 7'b100_0111) begin
            err_cnt++;
            $display("FAIL collide_next: got %b expected %b", {busy, req_ack, msg_done, inst_rst}, 7'b100_0111);
        end
        step();
        cmp_cnt++;
        if (window !== SLOT3) begin
            err_cnt++;
            $display("FAIL collide_window: got %h expected %h", window, SLOT3);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic test_abort_and_reset();
        int done_seen;
        done_seen = 0;
        start_msg(2'd2);
        for (int i = 0; i < 5; i++) step();
        abort = 1'b1; req_valid = 1'b1; msg_id = 2'd0;
        step();
        abort = 1'b0; req_valid = 1'b0;
        cmp_cnt++;
        if ({busy, req_ack, msg_done, inst_rst} !== 7'b000_1111 || window !== 40'h0) begin
            err_cnt++;
            $display("FAIL abort_idle: got %b/%h expected %b/%h",
                     {busy, req_ack, msg_done, inst_rst}, window, 7'b000_1111, 40'h0);
        end
        step();
        cmp_cnt++;
        if ({busy, req_ack, msg_done} !== 3'b000) begin
            err_cnt++;
            $display("FAIL abort_stays_idle: got %b expected %b", {busy, req_ack, msg_done}, 3'b000);
        end
        start_msg(2'd3);
        for (int i = 0; i < 20; i++) step();
        rst = 1'b1; abort = 1'b1; req_valid = 1'b1; msg_id = 2'd1;
        step();
        rst = 1'b0; abort = 1'b0; req_valid = 1'b0;
        cmp_cnt++;
        if ({busy, req_ack, msg_done, inst_rst} !== 7'b000_1111 || window !== 40'h0) begin
            err_cnt++;
            $display("FAIL midplay_reset: got %b/%h expected %b/%h",
                     {busy, req_ack, msg_done, inst_rst}, window, 7'b000_1111, 40'h0);
        end
        for (int i = 0; i < 35; i++) begin
            step();
            if (msg_done === 1'b1 || busy === 1'b1) done_seen++;
        end
        cmp_cnt++;
        if (done_seen !== 0) begin
            err_cnt++;
            $display("FAIL reset_no_done: got %0d activity cycles expected %0d", done_seen, 0);
        end
    endtask

    initial begin
        test_reset();
        test_basic_play();
        test_window_tracking();
        test_preempt();
        test_same_id_and_load();
        test_final_collision();
        test_abort_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
